ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
- Registered, parametrised execute stage: operand select muxes, single-cycle ALU, and iterative multiplier (RV32M MUL/MULH/MULHSU/MULHU).
- Sits between ID and MEM with valid/ready handshakes on both sides.
- Holds its result until downstream accepts it, and supports a pipeline flush.
- Successor to the combinational EX stage; adds XLEN generalisation, registered output, stall/flush, and multi-cycle ops.

Parameters:
- XLEN, 32, datapath width; must be at least 8 and a power of two.
- MUL_EN, 1, 1 = multiplier present; 0 = mul requests are executed as ALU ADD.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of in-flight and held results.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage can accept an operation this cycle.
- alu_sel  in  4  ALU op code (package encoding).
- is_mul  in  1  operation is a multiply; mul_op is used, alu_sel is ignored.
- mul_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- data_A  in  XLEN  rs1 value.
- data_B  in  XLEN  rs2 value.
- immediate  in  XLEN  sign-extended immediate.
- pc  in  XLEN  instruction address.
- mux_A_sel  in  1  1 = operand A is pc, 0 = data_A.
- mux_B_sel  in  1  1 = operand B is immediate, 0 = data_B.
- out_valid  out  1  data_out holds a valid result.
- out_ready  in  1  downstream accepts the result.
- data_out  out  XLEN  registered result.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, out_valid = 0, data_out = 0, multiplier registers = 0. in_ready follows from state = 1 once reset is released.
- Operand selection is combinational at acceptance time. The multiplier always uses data_A and data_B, ignoring the mux selects.
- in_ready = (state == IDLE) && !flush && (!out_valid || out_ready).
- Acceptance: edge where in_valid && in_ready.
- ALU op accepted at edge N: data_out registered and out_valid = 1 after edge N.
- ALU encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
  - 11–15 produce 0.
  - Shift amount is the low log2(XLEN) bits of B.
  - Arithmetic wraps modulo 2^XLEN.
- Multiply (MUL_EN = 1), accepted at edge N:
  - IDLE → MUL. Latch |A| and |B| per signedness (MULH: both signed; MULHSU: A signed, B unsigned; MUL, MULHU: unsigned). Record result sign and hi/lo select.
  - MUL: one radix-2 shift-add iteration per edge, counter 0..XLEN-1, 2·XLEN-bit accumulator.
  - After the XLEN-th iteration edge (N+XLEN) → DONE.
  - DONE: negate the accumulator if the sign flag is set, select the low half (MUL) or high half (others), register into data_out with out_valid = 1 at edge N+XLEN+1; state → IDLE at the same edge.
  - If out_valid is still held at the DONE edge (downstream stalled), remain in DONE until out_ready; the result is not lost.
- Result hold: while out_valid && !out_ready, data_out and out_valid are stable.
- out_valid falls on the edge where out_ready is high, unless a new result is loaded at the same edge (back-to-back ALU ops give throughput 1/cycle).
- flush (synchronous, highest priority after reset):
  - At the edge: out_valid = 0, state → IDLE, multiply aborted.
  - No acceptance occurs in a flush cycle.
  - data_out value is don't-care but is left unchanged.
- Multiply latency is XLEN+1 edges from acceptance to out_valid; in_ready stays low throughout.
- Edge cases:
  - Signed MULH of the most-negative value × the most-negative value must give the correct high word (0x4000_0000 for XLEN = 32).
  - MUL by 0 still takes the full latency.

Decomposition:
- Package ex_pkg holds: the ALU op localparams (ALU_ADD…ALU_PASS_B), MUL_OP codes, and state encoding (IDLE, MUL, DONE).
- Sub-module alu_param(XLEN): a purely combinational ALU, reused by the top.
- The iterative multiplier is the FSM in the top module.

Test Plan:
- Reset mid-multiply: drop rst_n at iteration 10 → out_valid = 0 and in_ready = 1 immediately after release; no stale result appears.
- ALU streaming, out_ready = 1: ADD 5+7, SUB 3−5, SRA 0x8000_0000 by 4 on consecutive cycles → data_out = 12, 0xFFFF_FFFE, 0xF800_0000 on consecutive cycles; in_ready stays 1.
- Operand muxes: mux_A_sel = 1, pc = 0x100, mux_B_sel = 1, immediate = 0xFFFF_FFFC, ADD → 0xFC.
- Multiply variants, each with out_valid exactly 33 edges after acceptance:
  - MUL 0xFFFF_FFFF × 0xFFFF_FFFF → 0x0000_0001.
  - MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
  - MULH −2 × 3 → 0xFFFF_FFFF.
  - MULHSU −1 × 0xFFFF_FFFF → 0xFFFF_FFFF.
- Backpressure: hold out_ready = 0 for 5 cycles after an ALU result → data_out stable and in_ready = 0. Release → one transfer, then the next op is accepted.
- Flush: assert flush during MUL iteration 7 and again while a result is held → out_valid = 0 next edge, state IDLE. A following ADD 1+1 yields 2 with latency 1.

Source files
------------

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_pkg
// Purpose  : Shared encodings for the execute stage: ALU op codes, multiply
//            op codes and the multiplier sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
package ex_pkg;

  // ALU operation codes; 11..15 are unassigned and yield zero
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // RV32M multiply flavours
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  // Execute-stage sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ex_stage_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu_param
// Purpose  : Purely combinational XLEN-wide ALU. Shifts use the low
//            log2(XLEN) bits of op_b; arithmetic wraps modulo 2^XLEN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_param
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  logic           lt_signed;
  logic           lt_unsigned;

  assign shamt       = op_b[SHW-1:0];
  assign lt_signed   = $signed(op_a) < $signed(op_b);
  assign lt_unsigned = op_a < op_b;

  // Operation select; unassigned codes fall through to zero
  always_comb begin
    result = '0;
    case (alu_sel)
      ALU_ADD:    result = op_a + op_b;
      ALU_SUB:    result = op_a - op_b;
      ALU_SLL:    result = op_a << shamt;
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:    result = op_a ^ op_b;
      ALU_SRL:    result = op_a >> shamt;
      ALU_SRA:    result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:     result = op_a | op_b;
      ALU_AND:    result = op_a & op_b;
      ALU_PASS_B: result = op_b;
      default:    result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pipe
// Purpose  : Registered execute stage with valid/ready on both sides.
//            ALU ops complete in one cycle; multiplies run an XLEN-step
//            radix-2 shift-add on magnitudes, then fix the sign in DONE.
//            The result register holds until downstream accepts it.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_pipe
  import ex_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MUL_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic            is_mul,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] data_A,
  input  logic [XLEN-1:0] data_B,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] pc,
  input  logic            mux_A_sel,
  input  logic            mux_B_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data_out
);

  localparam int              CNT_W       = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(XLEN - 1);
  localparam bit              MUL_PRESENT = (MUL_EN != 0);

  // Registered state
  state_e              state_q,     state_d;
  logic                out_valid_q, out_valid_d;
  logic [XLEN-1:0]     data_out_q,  data_out_d;
  logic [XLEN-1:0]     mcand_q,     mcand_d;
  logic [2*XLEN-1:0]   acc_q,       acc_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                neg_q,       neg_d;
  logic                hi_q,        hi_d;

  // Combinational helpers
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [3:0]        alu_op;
  logic [XLEN-1:0]   alu_result;
  logic              mul_req;
  logic              out_free;
  logic              accept;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN:0]     step_sum;
  logic [2*XLEN-1:0] prod_fixed;
  logic [XLEN-1:0]   mul_result;

  assign op_a     = mux_A_sel ? pc : data_A;
  assign op_b     = mux_B_sel ? immediate : data_B;
  // Without a multiplier a multiply request degrades to ADD on the muxed operands
  assign alu_op   = is_mul ? ALU_ADD : alu_sel;
  assign mul_req  = is_mul && MUL_PRESENT;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_IDLE) && !flush && out_free;
  assign accept   = in_valid && in_ready;

  // Magnitudes of the raw register operands per the op's signedness
  assign a_neg = ((mul_op == MUL_OP_MULH) || (mul_op == MUL_OP_MULHSU)) && data_A[XLEN-1];
  assign b_neg = (mul_op == MUL_OP_MULH) && data_B[XLEN-1];
  assign a_abs = a_neg ? -data_A : data_A;
  assign b_abs = b_neg ? -data_B : data_B;

  // One shift-add step: add multiplicand into the upper half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  assign step_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_fixed = neg_q ? -acc_q : acc_q;
  assign mul_result = hi_q ? prod_fixed[2*XLEN-1:XLEN] : prod_fixed[XLEN-1:0];

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

  alu_param #(
    .XLEN (XLEN)
  ) u_alu (
    .alu_sel (alu_op),
    .op_a    (op_a),
    .op_b    (op_b),
    .result  (alu_result)
  );

  // Next-state: sequencer, result register and multiplier datapath
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    hi_d        = hi_q;

    // A held result retires whenever downstream takes it; a new load overrides
    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (mul_req) begin
              mcand_d = a_abs;
              acc_d   = {{XLEN{1'b0}}, b_abs};
              cnt_d   = '0;
              neg_d   = a_neg ^ b_neg;
              hi_d    = (mul_op != MUL_OP_MUL);
              state_d = ST_MUL;
            end else begin
              data_out_d  = alu_result;
              out_valid_d = 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_d = {step_sum, acc_q[XLEN-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // Wait here if an older result is still stalled downstream
          if (out_free) begin
            data_out_d  = mul_result;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      hi_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      hi_q        <= hi_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage_pipe
// Purpose  : Scoreboard bench for ex_stage_pipe (XLEN = 32, multiplier on).
//            The driver pushes model results; a monitor pops on each transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_sel = 4'd0;
  logic        is_mul = 1'b0;
  logic [1:0]  mul_op = 2'd0;
  logic [31:0] data_A = '0;
  logic [31:0] data_B = '0;
  logic [31:0] immediate = '0;
  logic [31:0] pc = '0;
  logic        mux_A_sel = 1'b0;
  logic        mux_B_sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] data_out;

  ex_stage_pipe #(.XLEN(32), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .is_mul(is_mul), .mul_op(mul_op),
    .data_A(data_A), .data_B(data_B), .immediate(immediate), .pc(pc),
    .mux_A_sel(mux_A_sel), .mux_B_sel(mux_B_sel),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          vcyc;   // cycle the result must first show valid, -1 = unchecked
    int          id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   opn = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: full-width product for multiplies, plain operators for the ALU
  function automatic logic [31:0] ref_model(input logic m, input logic [1:0] mop,
      input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic [31:0] pcv, input logic ma, input logic mb);
    logic [63:0] ax, bx, p;
    logic [31:0] x, y;
    int sh;
    if (m) begin
      ax = (mop == 2'b01 || mop == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
      bx = (mop == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ax * bx;
      return (mop == 2'b00) ? p[31:0] : p[63:32];
    end
    x  = ma ? pcv : a;
    y  = mb ? imm : b;
    sh = int'(y[4:0]);
    case (sel)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x << sh;
      4'd3:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4:  return (x < y) ? 32'd1 : 32'd0;
      4'd5:  return x ^ y;
      4'd6:  return x >> sh;
      4'd7:  return $unsigned($signed(x) >>> sh);
      4'd8:  return x | y;
      4'd9:  return x & y;
      4'd10: return y;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Drive one op (call just after a rising edge); returns after its acceptance edge
  task automatic issue(input logic m, input logic [1:0] mop, input logic [3:0] sel,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
      input logic [31:0] pcv, input logic ma, input logic mb, input int lat,
      output int waited);
    exp_t e;
    is_mul = m; mul_op = mop; alu_sel = sel; data_A = a; data_B = b;
    immediate = imm; pc = pcv; mux_A_sel = ma; mux_B_sel = mb;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout op=%0d in_ready=%b expected=1", opn, in_ready);
      in_valid = 1'b0;
      return;
    end
    e.data = ref_model(m, mop, sel, a, b, imm, pcv, ma, mb);
    e.vcyc = (lat < 0) ? -1 : cyc + 1 + lat;
    e.id   = opn;
    opn++;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d out_valid=%b expected=0", sb.size(), out_valid);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every accepted transfer is popped and compared
  initial begin : monitor
    logic prev_v, prev_x;
    int fresh;
    exp_t e;
    prev_v = 1'b0; prev_x = 1'b0; fresh = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0; prev_x = 1'b0;
      end else begin
        if (out_valid && (!prev_v || prev_x)) fresh = cyc;
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got=%h expected=none", data_out);
          end else begin
            e = sb.pop_front();
            if (data_out !== e.data) begin
              errors++;
              $display("FAIL result op=%0d got=%h expected=%h", e.id, data_out, e.data);
            end
            if (e.vcyc >= 0) begin
              checks++;
              if (fresh != e.vcyc) begin
                errors++;
                $display("FAIL latency op=%0d got_cycle=%0d expected_cycle=%0d", e.id, fresh, e.vcyc);
              end
            end
          end
        end
        prev_v = out_valid;
        prev_x = out_valid && out_ready;
      end
    end
  end

  // Random backpressure generator, active only in the random phase
  initial begin : rdy_gen
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog_timeout cycle=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int w, w1, w2;
    logic [31:0] held;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // ALU streaming at one op per cycle
    issue(1'b0, 2'd0, 4'd0, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 0, w);
    issue(1'b0, 2'd0, 4'd1, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 0, w1);
    issue(1'b0, 2'd0, 4'd7, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 0, w2);
    chk("stream_in_ready_waits", w + w1 + w2, 32'd0);

    // Operand muxes
    issue(1'b0, 2'd0, 4'd0, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFC, 32'h100,
          1'b1, 1'b1, 0, w);
    wait_drain();

    // Multiply variants, 33-edge latency each
    issue(1'b1, 2'b00, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 33, w);
    issue(1'b1, 2'b11, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 33, w);
    issue(1'b1, 2'b01, 4'd0, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 33, w);
    issue(1'b1, 2'b10, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 33, w);
    issue(1'b1, 2'b01, 4'd0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b1, 33, w);
    issue(1'b1, 2'b00, 4'd0, 32'h1234_5678, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 33, w);
    wait_drain();

    // Backpressure: result held for 5 cycles
    out_ready = 1'b0;
    held = ref_model(1'b0, 2'd0, 4'd0, 32'h11, 32'h22, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(1'b0, 2'd0, 4'd0, 32'h11, 32'h22, 32'd0, 32'd0, 1'b0, 1'b0, 0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_data_out", data_out, held);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(1'b0, 2'd0, 4'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0, w);
    wait_drain();

    // Flush during multiply iteration 7
    issue(1'b1, 2'b01, 4'd0, 32'h7654_3210, 32'h8765_4321, 32'd0, 32'd0, 1'b0, 1'b0, 33, w);
    repeat (6) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_mul_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_mul_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    issue(1'b0, 2'd0, 4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 0, w);
    wait_drain();

    // Flush while a result is held
    out_ready = 1'b0;
    held = ref_model(1'b0, 2'd0, 4'd5, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'd0, 32'd0, 1'b0, 1'b0);
    issue(1'b0, 2'd0, 4'd5, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'd0, 32'd0, 1'b0, 1'b0, 0, w);
    @(negedge clk);
    chk("held_before_flush", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_held_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_held_data_kept", data_out, held);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(1'b0, 2'd0, 4'd0, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 0, w);
    wait_drain();

    // Reset in the middle of a multiply
    issue(1'b1, 2'b11, 4'd0, 32'hCAFE_F00D, 32'h1357_9BDF, 32'd0, 32'd0, 1'b0, 1'b0, 33, w);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_data_out", data_out, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_release_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    // Randomised mix with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic m;
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      m = ($urandom_range(0, 3) == 0);
      issue(m, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), m ? -1 : 0, w);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
